// File: rtl/mips_cpu_bus_master.sv
// Load/store bus initiator: turns one core byte/half/word request into a single
// word-addressed read or write, honouring waitrequest, and returns extended load data.
module mips_cpu_bus_master #(
   parameter int RESET_VECTOR_UNUSED = 0,
   parameter int TIMEOUT             = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] address,
   output logic        write,
   output logic        read,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   if (RESET_VECTOR_UNUSED != 0) begin : g_bad_param
      $error("RESET_VECTOR_UNUSED is reserved and must be 0");
   end

   typedef enum logic [1:0] {IDLE, BUS, CAPTURE, RESP} state_t;

   state_t             state_reg, state_next;
   logic               read_reg, read_next;
   logic               write_reg, write_next;
   logic [31:0]        address_reg, address_next;
   logic [31:0]        writedata_reg, writedata_next;
   logic [3:0]         byteenable_reg, byteenable_next;
   logic               resp_valid_reg, resp_valid_next;
   logic               resp_err_reg, resp_err_next;
   logic [31:0]        resp_rdata_reg, resp_rdata_next;
   logic               req_ready_reg, req_ready_next;
   logic [1:0]         lane_reg, lane_next;
   logic [1:0]         size_reg, size_next;
   logic               signed_reg, signed_next;
   logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;

   logic               misaligned;
   logic [3:0]         req_be;
   logic [31:0]        req_wd;
   logic [7:0]         rd_byte [4];
   logic [7:0]         sel_byte;
   logic [15:0]        sel_half;
   logic [31:0]        load_ext;

   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = readdata[8*gi +: 8];
   end

   always_comb begin
      misaligned = 1'b0;
      req_be     = 4'b1111;
      req_wd     = req_wdata;
      case (req_size)
         2'd0: begin
            req_be = 4'b0001 << req_addr[1:0];
            req_wd = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            misaligned = req_addr[0];
            req_be     = req_addr[1] ? 4'b1100 : 4'b0011;
            req_wd     = {2{req_wdata[15:0]}};
         end
         2'd2: misaligned = (req_addr[1:0] != 2'b00);
         default: misaligned = 1'b1;
      endcase
   end

   // Lane selection uses the latched request, since the bus address has [1:0] cleared.
   always_comb begin
      sel_byte = rd_byte[lane_reg];
      sel_half = lane_reg[1] ? readdata[31:16] : readdata[15:0];
      case (size_reg)
         2'd0:    load_ext = {{24{signed_reg & sel_byte[7]}}, sel_byte};
         2'd1:    load_ext = {{16{signed_reg & sel_half[15]}}, sel_half};
         default: load_ext = readdata;
      endcase
   end

   always_comb begin
      state_next      = state_reg;
      read_next       = read_reg;
      write_next      = write_reg;
      address_next    = address_reg;
      writedata_next  = writedata_reg;
      byteenable_next = byteenable_reg;
      resp_valid_next = 1'b0;
      resp_err_next   = 1'b0;
      resp_rdata_next = resp_rdata_reg;
      lane_next       = lane_reg;
      size_next       = size_reg;
      signed_next     = signed_reg;
      wait_cnt_next   = wait_cnt_reg;

      case (state_reg)
         IDLE: begin
            if (req_valid && req_ready_reg) begin
               if (misaligned) begin
                  state_next      = RESP;
                  resp_valid_next = 1'b1;
                  resp_err_next   = 1'b1;
               end else begin
                  state_next      = BUS;
                  address_next    = {req_addr[31:2], 2'b00};
                  byteenable_next = req_be;
                  writedata_next  = req_wd;
                  read_next       = ~req_write;
                  write_next      = req_write;
                  lane_next       = req_addr[1:0];
                  size_next       = req_size;
                  signed_next     = req_signed;
                  wait_cnt_next   = '0;
               end
            end
         end
         BUS: begin
            if (!waitrequest) begin
               read_next  = 1'b0;
               write_next = 1'b0;
               if (write_reg) begin
                  state_next      = RESP;
                  resp_valid_next = 1'b1;
               end else begin
                  state_next = CAPTURE;
               end
            end else if (TIMEOUT != 0 && (int'(wait_cnt_reg) + 1) == TIMEOUT) begin
               read_next       = 1'b0;
               write_next      = 1'b0;
               state_next      = RESP;
               resp_valid_next = 1'b1;
               resp_err_next   = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt_reg + 1'b1;
            end
         end
         CAPTURE: begin
            resp_rdata_next = load_ext;
            state_next      = RESP;
            resp_valid_next = 1'b1;
         end
         default: state_next = IDLE;
      endcase

      req_ready_next = (state_next == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         read_reg       <= 1'b0;
         write_reg      <= 1'b0;
         address_reg    <= '0;
         writedata_reg  <= '0;
         byteenable_reg <= '0;
         resp_valid_reg <= 1'b0;
         resp_err_reg   <= 1'b0;
         resp_rdata_reg <= '0;
         req_ready_reg  <= 1'b1;
         lane_reg       <= '0;
         size_reg       <= '0;
         signed_reg     <= 1'b0;
         wait_cnt_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         read_reg       <= read_next;
         write_reg      <= write_next;
         address_reg    <= address_next;
         writedata_reg  <= writedata_next;
         byteenable_reg <= byteenable_next;
         resp_valid_reg <= resp_valid_next;
         resp_err_reg   <= resp_err_next;
         resp_rdata_reg <= resp_rdata_next;
         req_ready_reg  <= req_ready_next;
         lane_reg       <= lane_next;
         size_reg       <= size_next;
         signed_reg     <= signed_next;
         wait_cnt_reg   <= wait_cnt_next;
      end
   end

   assign req_ready  = req_ready_reg;
   assign resp_valid = resp_valid_reg;
   assign resp_err   = resp_err_reg;
   assign resp_rdata = resp_rdata_reg;
   assign address    = address_reg;
   assign write      = write_reg;
   assign read       = read_reg;
   assign writedata  = writedata_reg;
   assign byteenable = byteenable_reg;

endmodule
